gpmc_sync_master: RTL and testbench
===================================

// Module: gpmc_sync_master
// PURPOSE
//  Initiator end of the synchronous multiplexed GPMC bus (csn1/advn/oen/wein, 16-bit AD, gpmc_clk).
//  Turns single-word host read/write requests into GPMC address+data cycles that the FPGA GPMC slave decodes.
//  Used as bench bus-functional driver and for FPGA-to-FPGA GPMC links.
//  Bus outputs launch on gpmc_clk rise; slave samples on gpmc_clk fall.
// PARAMETERS
//  ADDR_WIDTH   16  request address width (<=16), zero-extended onto AD
//  DATA_WIDTH   16  data width (<=16), zero-extended on write, low bits taken on read
//  CLK_DIV      2   gpmc_clk half-period in clk cycles (>=1); one gpmc cycle = 2*CLK_DIV clk
//  ADDR_CYC     1   gpmc cycles with advn low (address phase)
//  WR_CYC       4   gpmc cycles with wein low (covers slave 2-flop sync)
//  RD_CYC       6   gpmc cycles with oen low before read sample
//  RECOVER_CYC  1   gpmc cycles, csn1 high, AD released, between transactions
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   host request valid
//  req_ready    out  1   request accepted when req_valid & req_ready
//  req_we       in   1   1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH  word address
//  req_wdata    in   DATA_WIDTH  write data
//  rsp_valid    out  1   one-clk pulse, transaction complete (read and write)
//  rsp_rdata    out  DATA_WIDTH  read data, valid with rsp_valid on reads
//  busy         out  1   transaction in progress (not IDLE)
//  gpmc_clk     out  1   generated bus clock
//  gpmc_csn1    out  1   chip select, active low
//  gpmc_advn    out  1   address valid, active low
//  gpmc_oen     out  1   output enable, active low
//  gpmc_wein    out  1   write enable, active low
//  gpmc_ad_o    out  16  AD drive value
//  gpmc_ad_oe   out  1   AD tri-state enable (1 = drive)
//  gpmc_ad_i    in   16  AD sampled value
// BEHAVIOUR
//  Reset (async, immediate, incl. mid-transaction): csn1/advn/oen/wein=1, ad_oe=0, ad_o=0, gpmc_clk=0,
//   req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, state IDLE, counters 0. req_ready=1 first clk after release.
//  Clock gen: divider counts 0..CLK_DIV-1, toggles gpmc_clk on wrap. Phase changes only in the clk where gpmc_clk 0->1.
//  Handshake: req_ready=1 only in IDLE; accept registers we/addr/wdata, drops req_ready, busy=1 next clk.
//  FSM (transitions at gpmc_clk rising edges, counted in gpmc cycles):
//   IDLE    : bus idle values; on accepted request -> ADDR at next rising edge.
//   ADDR    : csn1=0 advn=0 oen=1 wein=1 ad_oe=1 ad_o=addr; ADDR_CYC cycles -> WRITE or READ.
//   WRITE   : csn1=0 advn=1 wein=0 oen=1 ad_oe=1 ad_o=wdata; WR_CYC cycles -> RECOVER.
//   READ    : csn1=0 advn=1 oen=0 wein=1 ad_oe=0; ad_oe drops in the same clk as advn rises;
//             gpmc_ad_i captured in the clk before the final rising edge of READ; -> RECOVER.
//   RECOVER : all strobes 1, ad_oe=0; RECOVER_CYC cycles; rsp_valid pulses 1 clk on entry to IDLE.
//  rsp_rdata updates only on reads, holds otherwise. ad_oe=1 never coincides with oen=0.
//  Only one outstanding transaction; req_valid during busy is ignored (no queue).
//  Counters sized to hold max(ADDR_CYC,WR_CYC,RD_CYC,RECOVER_CYC); no wrap within a phase.
// CONFIGURATION
//  GPMC_CLK_FREE_RUN_EN defined: gpmc_clk toggles continuously out of reset; request waits for next rising edge.
//  Not defined: gpmc_clk held 0 in IDLE; divider restarts on accept, first rise CLK_DIV clks after accept,
//   gpmc_clk returns to 0 and stops after the last RECOVER cycle.
// TESTING (defaults, CLK_DIV=2 => 4 clk per gpmc cycle; behavioural slave model on AD)
//  Write addr 0x0012 data 0xBEEF -> advn=0/ad_o=0x0012 for 4 clk, wein=0/ad_o=0xBEEF for 16 clk,
//   csn1=1 4 clk, one rsp_valid; slave model records 0xBEEF at 0x0012.
//  Read addr 0x0034, model drives 0x5A5A while oen=0 -> oen=0 for 24 clk, ad_oe=0 throughout, rsp_rdata=0x5A5A.
//  req_valid held for write then read -> second accept only after rsp_valid; csn1 high >=4 clk between.
//  rst_n low mid-WRITE -> strobes 1, ad_oe=0 same cycle; after release req_ready=1, no rsp_valid.
//  Assertion over random traffic: never (ad_oe & !oen); advn low only with csn1 low.
//  Run with and without GPMC_CLK_FREE_RUN_EN: gpmc_clk idle-stopped at 0 only when undefined; same bus data.

Source files
------------

// File: rtl/gpmc_sync_master.sv
// Synchronous multiplexed GPMC initiator: single-word host requests become ADDR/WRITE|READ/RECOVER bus cycles.
// Optional build macro GPMC_CLK_FREE_RUN_EN keeps gpmc_clk toggling continuously instead of stopping when idle.
module gpmc_sync_master #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int CLK_DIV     = 2,
    parameter int ADDR_CYC    = 1,
    parameter int WR_CYC      = 4,
    parameter int RD_CYC      = 6,
    parameter int RECOVER_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  gpmc_clk,
    output logic                  gpmc_csn1,
    output logic                  gpmc_advn,
    output logic                  gpmc_oen,
    output logic                  gpmc_wein,
    output logic [15:0]           gpmc_ad_o,
    output logic                  gpmc_ad_oe,
    input  logic [15:0]           gpmc_ad_i
);
    localparam int MAX_AW  = (ADDR_CYC > WR_CYC) ? ADDR_CYC : WR_CYC;
    localparam int MAX_RR  = (RD_CYC > RECOVER_CYC) ? RD_CYC : RECOVER_CYC;
    localparam int MAX_CYC = (MAX_AW > MAX_RR) ? MAX_AW : MAX_RR;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WRITE,
        ST_READ,
        ST_RECOVER
    } state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cyc_cnt_reg, cyc_cnt_next;
    logic [DW-1:0]           div_cnt_reg, div_cnt_next;
    logic                    gpmc_clk_reg, gpmc_clk_next;
    logic                    busy_reg, busy_next;
    logic                    ready_reg;
    logic                    rsp_valid_reg;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
    logic [DATA_WIDTH-1:0]   rd_cap_reg;
    logic                    we_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic                    csn_reg, csn_next;
    logic                    advn_reg, advn_next;
    logic                    oen_reg, oen_next;
    logic                    wein_reg, wein_next;
    logic                    ad_oe_reg, ad_oe_next;
    logic [15:0]             ad_o_reg, ad_o_next;

    logic accept;
    logic clk_run;
    logic div_wrap;
    logic rise_tick;
    logic pre_rise;
    logic to_idle;
    logic capture;

    assign accept = req_valid && ready_reg;

`ifdef GPMC_CLK_FREE_RUN_EN
    assign clk_run = 1'b1;
`else
    assign clk_run = busy_reg;
`endif

    assign div_wrap  = clk_run && (div_cnt_reg == DW'(CLK_DIV - 1));
    assign rise_tick = div_wrap && !gpmc_clk_reg;

    // pre_rise marks the clk immediately before a gpmc_clk rising edge
    generate
        if (CLK_DIV > 1) begin : g_pre_div
            assign pre_rise = clk_run && !gpmc_clk_reg && (div_cnt_reg == DW'(CLK_DIV - 2));
        end else begin : g_pre_one
            assign pre_rise = clk_run && gpmc_clk_reg;
        end
    endgenerate

    assign capture = pre_rise && (state_reg == ST_READ) && (cyc_cnt_reg == CW'(RD_CYC - 1));

    always_comb begin
        div_cnt_next  = div_cnt_reg;
        gpmc_clk_next = gpmc_clk_reg;
        if (clk_run) begin
            div_cnt_next = div_wrap ? '0 : div_cnt_reg + DW'(1);
            if (div_wrap) begin
`ifdef GPMC_CLK_FREE_RUN_EN
                gpmc_clk_next = !gpmc_clk_reg;
`else
                // the rise that would end the last RECOVER cycle is suppressed: clock parks at 0
                gpmc_clk_next = !gpmc_clk_reg && !to_idle;
`endif
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cyc_cnt_next = cyc_cnt_reg;
        to_idle      = 1'b0;
        if (rise_tick) begin
            case (state_reg)
                ST_IDLE: begin
                    if (busy_reg) begin
                        state_next   = ST_ADDR;
                        cyc_cnt_next = '0;
                    end
                end
                ST_ADDR: begin
                    if (cyc_cnt_reg == CW'(ADDR_CYC - 1)) begin
                        state_next   = we_reg ? ST_WRITE : ST_READ;
                        cyc_cnt_next = '0;
                    end else begin
                        cyc_cnt_next = cyc_cnt_reg + CW'(1);
                    end
                end
                ST_WRITE: begin
                    if (cyc_cnt_reg == CW'(WR_CYC - 1)) begin
                        state_next   = ST_RECOVER;
                        cyc_cnt_next = '0;
                    end else begin
                        cyc_cnt_next = cyc_cnt_reg + CW'(1);
                    end
                end
                ST_READ: begin
                    if (cyc_cnt_reg == CW'(RD_CYC - 1)) begin
                        state_next   = ST_RECOVER;
                        cyc_cnt_next = '0;
                    end else begin
                        cyc_cnt_next = cyc_cnt_reg + CW'(1);
                    end
                end
                ST_RECOVER: begin
                    if (cyc_cnt_reg == CW'(RECOVER_CYC - 1)) begin
                        state_next   = ST_IDLE;
                        cyc_cnt_next = '0;
                        to_idle      = 1'b1;
                    end else begin
                        cyc_cnt_next = cyc_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_next   = ST_IDLE;
                    cyc_cnt_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy_next = busy_reg;
        if (accept) begin
            busy_next = 1'b1;
        end else if (to_idle) begin
            busy_next = 1'b0;
        end
    end

    // Bus strobes are decoded from the next state and registered, so they change cleanly on the rise clk
    always_comb begin
        csn_next   = 1'b1;
        advn_next  = 1'b1;
        oen_next   = 1'b1;
        wein_next  = 1'b1;
        ad_oe_next = 1'b0;
        ad_o_next  = '0;
        case (state_next)
            ST_ADDR: begin
                csn_next   = 1'b0;
                advn_next  = 1'b0;
                ad_oe_next = 1'b1;
                ad_o_next  = 16'(addr_reg);
            end
            ST_WRITE: begin
                csn_next   = 1'b0;
                wein_next  = 1'b0;
                ad_oe_next = 1'b1;
                ad_o_next  = 16'(wdata_reg);
            end
            ST_READ: begin
                csn_next = 1'b0;
                oen_next = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cyc_cnt_reg   <= '0;
            div_cnt_reg   <= '0;
            gpmc_clk_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rd_cap_reg    <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            csn_reg       <= 1'b1;
            advn_reg      <= 1'b1;
            oen_reg       <= 1'b1;
            wein_reg      <= 1'b1;
            ad_oe_reg     <= 1'b0;
            ad_o_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            cyc_cnt_reg   <= cyc_cnt_next;
            div_cnt_reg   <= div_cnt_next;
            gpmc_clk_reg  <= gpmc_clk_next;
            busy_reg      <= busy_next;
            ready_reg     <= !busy_next;
            rsp_valid_reg <= to_idle;
            csn_reg       <= csn_next;
            advn_reg      <= advn_next;
            oen_reg       <= oen_next;
            wein_reg      <= wein_next;
            ad_oe_reg     <= ad_oe_next;
            ad_o_reg      <= ad_o_next;
            if (accept) begin
                we_reg    <= req_we;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (capture) begin
                rd_cap_reg <= gpmc_ad_i[DATA_WIDTH-1:0];
            end
            if (to_idle && !we_reg) begin
                rsp_rdata_reg <= rd_cap_reg;
            end
        end
    end

    assign req_ready  = ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_rdata  = rsp_rdata_reg;
    assign busy       = busy_reg;
    assign gpmc_clk   = gpmc_clk_reg;
    assign gpmc_csn1  = csn_reg;
    assign gpmc_advn  = advn_reg;
    assign gpmc_oen   = oen_reg;
    assign gpmc_wein  = wein_reg;
    assign gpmc_ad_oe = ad_oe_reg;
    assign gpmc_ad_o  = ad_o_reg;

endmodule

// File: tb/tb_gpmc_sync_master.sv
// Bench for gpmc_sync_master: vector table of single transactions against a behavioural GPMC slave,
// plus back-to-back, idle-clock, random-traffic and mid-transaction reset sequences.
module tb_gpmc_sync_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        gpmc_clk;
    logic        gpmc_csn1;
    logic        gpmc_advn;
    logic        gpmc_oen;
    logic        gpmc_wein;
    logic [15:0] gpmc_ad_o;
    logic        gpmc_ad_oe;
    logic [15:0] gpmc_ad_i;

    gpmc_sync_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .gpmc_clk(gpmc_clk), .gpmc_csn1(gpmc_csn1), .gpmc_advn(gpmc_advn),
        .gpmc_oen(gpmc_oen), .gpmc_wein(gpmc_wein),
        .gpmc_ad_o(gpmc_ad_o), .gpmc_ad_oe(gpmc_ad_oe), .gpmc_ad_i(gpmc_ad_i)
    );

    always #5 clk = ~clk;

    // Behavioural slave: latches address and write data on gpmc_clk fall, drives AD while oen low
    logic [15:0] slave_addr = '0;
    logic [15:0] slave_mem [0:255];
    logic [15:0] exp_mem   [0:255];

    always @(negedge gpmc_clk) begin
        if (!gpmc_csn1) begin
            if (!gpmc_advn && gpmc_ad_oe) slave_addr = gpmc_ad_o;
            else if (!gpmc_wein && gpmc_ad_oe) slave_mem[slave_addr[7:0]] = gpmc_ad_o;
        end
    end
    assign gpmc_ad_i = (!gpmc_oen) ? slave_mem[slave_addr[7:0]] : 16'h0000;

    int n_checks = 0;
    int n_pass = 0;
    int prot_err = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (gpmc_ad_oe && !gpmc_oen) prot_err++;
            if (!gpmc_advn && gpmc_csn1) prot_err++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    int          n_advn, n_wein, n_oen, n_rsp, bad_adr, bad_wd, oe_bad, timed_out;
    logic        busy_after, ready_after;
    logic [15:0] got_rdata;

    task automatic do_txn(input logic we, input logic [15:0] a, input logic [15:0] d);
        int guard;
        int post;
        bit done;
        n_advn = 0; n_wein = 0; n_oen = 0; n_rsp = 0;
        bad_adr = 0; bad_wd = 0; oe_bad = 0; timed_out = 0;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        busy_after  = busy;
        ready_after = req_ready;
        done = 1'b0; post = 0; guard = 0;
        while (post < 4 && guard < 400) begin
            if (!gpmc_advn) begin
                n_advn++;
                if (gpmc_ad_o !== a || !gpmc_ad_oe) bad_adr++;
            end
            if (!gpmc_wein) begin
                n_wein++;
                if (gpmc_ad_o !== d || !gpmc_ad_oe) bad_wd++;
            end
            if (!gpmc_oen) begin
                n_oen++;
                if (gpmc_ad_oe) oe_bad++;
            end
            if (rsp_valid) begin
                n_rsp++;
                got_rdata = rsp_rdata;
                done = 1'b1;
            end
            if (done) post++;
            guard++;
            @(negedge clk);
        end
        timed_out = done ? 0 : 1;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          exp_advn;
        int          exp_wein;
        int          exp_oen;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          ones;
        int          n_acc, nr, ph, gap, guard;
        bit          acc_pending, acc2_after;
        logic [15:0] rd;
        logic        rw;
        logic [15:0] ra, rdv;

        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 16'h1000 + 16'(i);
            exp_mem[i]   = 16'h1000 + 16'(i);
        end
        slave_mem[8'h34] = 16'h5A5A;
        exp_mem[8'h34]   = 16'h5A5A;

        // {we, addr, wdata, advn clk, wein clk, oen clk, rsp_rdata}; writes leave rsp_rdata holding
        vecs[0] = '{1'b1, 16'h0012, 16'hBEEF, 4, 16, 0,  16'h0000};
        vecs[1] = '{1'b0, 16'h0034, 16'h0000, 4, 0,  24, 16'h5A5A};
        vecs[2] = '{1'b0, 16'h0012, 16'h0000, 4, 0,  24, 16'hBEEF};
        vecs[3] = '{1'b1, 16'h00FF, 16'h1234, 4, 16, 0,  16'hBEEF};
        vecs[4] = '{1'b0, 16'h00FF, 16'h0000, 4, 0,  24, 16'h1234};
        vecs[5] = '{1'b0, 16'h0035, 16'h0000, 4, 0,  24, 16'h1035};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bus", {27'd0, gpmc_csn1, gpmc_advn, gpmc_oen, gpmc_wein, gpmc_ad_oe}, 32'b11110);
        check("rst_hs", {29'd0, req_ready, rsp_valid, busy}, 32'd0);
        check("rst_clk_ad", {15'd0, gpmc_clk, gpmc_ad_o}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", req_ready, 32'd1);

        for (int v = 0; v < 6; v++) begin
            do_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata);
            $display("txn %0d we=%0d addr=%h wdata=%h advn=%0d wein=%0d oen=%0d rsp=%0d rdata=%h",
                     v, vecs[v].we, vecs[v].addr, vecs[v].wdata, n_advn, n_wein, n_oen, n_rsp, got_rdata);
            check($sformatf("v%0d_timeout", v), timed_out, 32'd0);
            check($sformatf("v%0d_busy_ready", v), {30'd0, busy_after, ready_after}, 32'b10);
            check($sformatf("v%0d_advn_clks", v), n_advn, vecs[v].exp_advn);
            check($sformatf("v%0d_wein_clks", v), n_wein, vecs[v].exp_wein);
            check($sformatf("v%0d_oen_clks", v), n_oen, vecs[v].exp_oen);
            check($sformatf("v%0d_ad_values", v), bad_adr + bad_wd + oe_bad, 32'd0);
            check($sformatf("v%0d_rsp_count", v), n_rsp, 32'd1);
            check($sformatf("v%0d_rsp_rdata", v), rsp_rdata, vecs[v].exp_rdata);
            if (vecs[v].we) begin
                check($sformatf("v%0d_slave_mem", v), slave_mem[vecs[v].addr[7:0]], vecs[v].wdata);
                exp_mem[vecs[v].addr[7:0]] = vecs[v].wdata;
            end
        end

        // Idle gpmc_clk behaviour
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (gpmc_clk) ones++;
            @(negedge clk);
        end
        $display("idle gpmc_clk high samples=%0d", ones);
`ifdef GPMC_CLK_FREE_RUN_EN
        check("idle_clk_running", (ones > 0) ? 1 : 0, 32'd1);
`else
        check("idle_clk_stopped", ones, 32'd0);
`endif

        // req_valid held across a write then a read
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0050; req_wdata = 16'h7E57;
        n_acc = 0; nr = 0; ph = 0; gap = 0; acc_pending = 1'b0; acc2_after = 1'b0; rd = '0;
        for (int c = 0; c < 400 && nr < 2; c++) begin
            if (rsp_valid) begin
                nr++;
                rd = rsp_rdata;
            end
            if (req_valid && req_ready) begin
                n_acc++;
                acc_pending = 1'b1;
                if (n_acc == 2) acc2_after = (nr >= 1);
            end
            case (ph)
                0: if (!gpmc_csn1) ph = 1;
                1: if (gpmc_csn1) begin ph = 2; gap = 1; end
                2: if (gpmc_csn1) gap++; else ph = 3;
                default: ;
            endcase
            @(negedge clk);
            if (acc_pending) begin
                acc_pending = 1'b0;
                if (n_acc == 1) req_we = 1'b0;
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        exp_mem[8'h50] = 16'h7E57;
        $display("b2b accepts=%0d rsps=%0d csn_gap=%0d rdata=%h", n_acc, nr, gap, rd);
        check("b2b_two_accepts", n_acc, 32'd2);
        check("b2b_accept_after_rsp", acc2_after, 32'd1);
        check("b2b_csn_gap_ge4", (gap >= 4) ? 1 : 0, 32'd1);
        check("b2b_read_data", rd, 32'h7E57);

        // Random traffic against a scoreboard memory
        for (int i = 0; i < 16; i++) begin
            rw  = 1'($urandom_range(0, 1));
            ra  = 16'h0040 + 16'($urandom_range(0, 15));
            rdv = 16'($urandom);
            do_txn(rw, ra, rdv);
            $display("rnd %0d we=%0d addr=%h wdata=%h rsp=%0d rdata=%h", i, rw, ra, rdv, n_rsp, got_rdata);
            if (rw) begin
                exp_mem[ra[7:0]] = rdv;
                check($sformatf("rnd%0d_wr_rsp", i), n_rsp, 32'd1);
            end else begin
                check($sformatf("rnd%0d_rd_data", i), got_rdata, exp_mem[ra[7:0]]);
            end
        end

        // Reset asserted in the middle of a write
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0077; req_wdata = 16'hCAFE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (gpmc_wein && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("midrst_reached_write", gpmc_wein, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_bus_idle", {27'd0, gpmc_csn1, gpmc_advn, gpmc_oen, gpmc_wein, gpmc_ad_oe}, 32'b11110);
        check("midrst_busy_clk", {30'd0, busy, gpmc_clk}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", req_ready, 32'd1);
        check("midrst_rdata_cleared", rsp_rdata, 32'd0);
        nr = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) nr++;
            @(negedge clk);
        end
        $display("midrst rsp pulses after release=%0d", nr);
        check("midrst_no_rsp", nr, 32'd0);

        check("protocol_violations", prot_err, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
